// File: rtl/chunked_add_sequencer.sv
// Multicycle W-bit adder: one CW-bit ripple adder reused over W/CW cycles,
// least-significant chunk first, with a registered inter-chunk carry.
module chunked_add_sequencer #(
    parameter int W  = 32,
    parameter int CW = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    output logic         ready,
    output logic         done,
    output logic [W-1:0] sum,
    output logic         c_out
);

    localparam int N     = W / CW;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] count;
    logic [W-1:0]     a_sh, b_sh;
    logic             carry;
    logic [CW-1:0]    chunk_sum;
    logic             chunk_co;
    logic [W-1:0]     chunk_ext;
    logic             accept, last_chunk;

    // The single narrow adder shared by every chunk cycle
    always_comb begin
        {chunk_co, chunk_sum} = {1'b0, a_sh[CW-1:0]} + {1'b0, b_sh[CW-1:0]}
                              + {{CW{1'b0}}, carry};
        chunk_ext = W'(chunk_sum);
    end

    assign accept     = start && ready;
    assign last_chunk = (state == RUN) && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (last_chunk) state_nxt = DONE;
            end
            DONE: begin
                ready     = 1'b1;
                done      = 1'b1;
                state_nxt = start ? RUN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operands drain from the LSB end while results enter the sum from the MSB end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (accept) begin
            count <= '0;
            carry <= c_in;
            a_sh  <= a;
            b_sh  <= b;
        end else if (state == RUN) begin
            count <= count + 1'b1;
            carry <= chunk_co;
            a_sh  <= a_sh >> CW;
            b_sh  <= b_sh >> CW;
            sum   <= (sum >> CW) | (chunk_ext << (W - CW));
            if (last_chunk) c_out <= chunk_co;
        end
    end

endmodule
